scaler_gen: RTL and testbench

- Parametrised successor to the fixed AGC scaler: a synchronous binary divider chain of STAGES stages driven from the master clock through a prescaler.
- Exposes true and complement stage outputs (FSnn) and one-cycle per-stage F-pulses.
- Provides a coherent two-channel read path (HISCALAR/LOSCALAR style), where a high-word read freezes the matching low word.
- Feeds timer/rupt logic and the I/O channel read bus.

---
 rtl/scaler_gen.sv | 131 +++++++++++++
 tb/tb_scaler_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/scaler_gen.sv
// rtl/scaler_gen.sv - prescaled binary scaler chain with stage pulses and coherent hi/lo channel reads
// Optional SCALER_STANDBY_EN adds sby/sbypls and gates pulses and reads during standby.
module scaler_gen #(
  parameter int STAGES   = 33,
  parameter int PRESCALE = 2,
  parameter int WORD     = 14,
  parameter int LO_BASE  = 6
`ifdef SCALER_STANDBY_EN
  ,
  parameter int SBY_STAGE = 16
`endif
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rchat_n,
  input  logic              rchbt_n,
  output logic [STAGES-1:0] fs,
  output logic [STAGES-1:0] fs_n,
  output logic [STAGES-1:0] fpls,
  output logic              wrap,
  output logic [WORD-1:0]   rd_data,
  output logic              rd_valid
`ifdef SCALER_STANDBY_EN
  ,
  input  logic              sby,
  output logic              sbypls
`endif
);

  logic              tick;
  logic [STAGES-1:0] cnt;
  logic [STAGES-1:0] cnt_nxt;
  logic [STAGES-1:0] rise;
  logic [WORD-1:0]   hi_word;
  logic [WORD-1:0]   lo_word;
  logic [WORD-1:0]   shadow;
  logic              shadow_vld;
  logic              rchat_q;
  logic              rchbt_q;
  logic              hi_rd;
  logic              lo_rd;
  logic              sby_i;
  logic              sby_rise;

  generate
    if (PRESCALE == 1) begin : g_nopre
      assign tick = en;
    end else begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] pcnt;

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
          pcnt <= '0;
        else if (en)
          pcnt <= (pcnt == PW'(PRESCALE - 1)) ? '0 : pcnt + PW'(1);
      end

      assign tick = en && (pcnt == PW'(PRESCALE - 1));
    end
  endgenerate

  assign cnt_nxt = cnt + STAGES'(1);
  assign rise    = ~cnt & cnt_nxt;
  assign fs      = cnt;
  assign fs_n    = ~cnt;

  // Shifting past the top of the counter yields zeros for out-of-range channel bits.
  assign hi_word = WORD'(cnt >> (LO_BASE + WORD));
  assign lo_word = WORD'(cnt >> LO_BASE);

  assign hi_rd = rchat_q & ~rchat_n;
  assign lo_rd = rchbt_q & ~rchbt_n;

`ifdef SCALER_STANDBY_EN
  logic sby_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sby_q  <= 1'b0;
      sbypls <= 1'b0;
    end else begin
      sby_q  <= sby;
      sbypls <= tick && rise[SBY_STAGE];
    end
  end

  assign sby_i    = sby;
  assign sby_rise = sby & ~sby_q;
`else
  assign sby_i    = 1'b0;
  assign sby_rise = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      fpls       <= '0;
      wrap       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      shadow     <= '0;
      shadow_vld <= 1'b0;
      rchat_q    <= 1'b1;
      rchbt_q    <= 1'b1;
    end else begin
      rchat_q  <= rchat_n;
      rchbt_q  <= rchbt_n;
      if (tick)
        cnt <= cnt_nxt;
      fpls     <= (tick && !sby_i) ? rise : '0;
      wrap     <= tick && !sby_i && (&cnt);
      rd_valid <= 1'b0;
      // A high read wins over a coincident low edge and snapshots the matching low word.
      if (!sby_i && hi_rd) begin
        rd_data    <= hi_word;
        shadow     <= lo_word;
        shadow_vld <= 1'b1;
        rd_valid   <= 1'b1;
      end else if (!sby_i && lo_rd) begin
        rd_data    <= shadow_vld ? shadow : lo_word;
        shadow_vld <= 1'b0;
        rd_valid   <= 1'b1;
      end else if (sby_rise) begin
        shadow_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scaler_gen.sv
// tb/tb_scaler_gen.sv - scoreboard bench for scaler_gen on two parameter sets
module tb_scaler_gen;

  localparam int SA = 12, PA = 2, WA = 4, LA = 2;
  localparam int SB = 4,  PB = 1, WB = 3, LB = 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic rchat_n = 1'b1;
  logic rchbt_n = 1'b1;

  logic [SA-1:0] fs_a, fs_n_a, fpls_a;
  logic          wrap_a, rd_valid_a;
  logic [WA-1:0] rd_data_a;
  logic [SB-1:0] fs_b, fs_n_b, fpls_b;
  logic          wrap_b, rd_valid_b;
  logic [WB-1:0] rd_data_b;
`ifdef SCALER_STANDBY_EN
  logic          sbypls_a, sbypls_b;
`endif

  always #5 clock = ~clock;

  scaler_gen #(.STAGES(SA), .PRESCALE(PA), .WORD(WA), .LO_BASE(LA)
`ifdef SCALER_STANDBY_EN
    , .SBY_STAGE(2)
`endif
  ) u_a (
    .clock(clock), .rst_n(rst_n), .en(en), .rchat_n(rchat_n), .rchbt_n(rchbt_n),
    .fs(fs_a), .fs_n(fs_n_a), .fpls(fpls_a), .wrap(wrap_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a)
`ifdef SCALER_STANDBY_EN
    , .sby(1'b0), .sbypls(sbypls_a)
`endif
  );

  scaler_gen #(.STAGES(SB), .PRESCALE(PB), .WORD(WB), .LO_BASE(LB)
`ifdef SCALER_STANDBY_EN
    , .SBY_STAGE(1)
`endif
  ) u_b (
    .clock(clock), .rst_n(rst_n), .en(en), .rchat_n(rchat_n), .rchbt_n(rchbt_n),
    .fs(fs_b), .fs_n(fs_n_b), .fpls(fpls_b), .wrap(wrap_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b)
`ifdef SCALER_STANDBY_EN
    , .sby(1'b0), .sbypls(sbypls_b)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  bit          checking = 1'b0;
  int          n_en = 0;
  bit          pa = 1'b1, pb = 1'b1;
  bit          sv_a = 1'b0, sv_b = 1'b0;
  logic [63:0] sh_a = '0, sh_b = '0;
  logic [63:0] last_a = '0, last_b = '0;
  logic [63:0] old_a = '0, old_b = '0;
  logic [63:0] ca, cb, new_a, new_b;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int s, input int p, input int n);
    logic [63:0] v;
    v = 64'(n / p);
    return v & ((64'd1 << s) - 64'd1);
  endfunction

  function automatic logic [63:0] field(input logic [63:0] c, input int base, input int w);
    return (c >> base) & ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: count = enabled cycles / PRESCALE; reads push expected data at the strobe edge.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      n_en = 0; pa = 1'b1; pb = 1'b1; sv_a = 1'b0; sv_b = 1'b0;
      sh_a = '0; sh_b = '0; last_a = '0; last_b = '0; old_a = '0; old_b = '0;
      q_a.delete(); q_b.delete();
    end else begin
      ca = cnt_of(SA, PA, n_en);
      cb = cnt_of(SB, PB, n_en);
      if (pa && !rchat_n) begin
        q_a.push_back(field(ca, LA + WA, WA)); sh_a = field(ca, LA, WA); sv_a = 1'b1;
        q_b.push_back(field(cb, LB + WB, WB)); sh_b = field(cb, LB, WB); sv_b = 1'b1;
      end else if (pb && !rchbt_n) begin
        q_a.push_back(sv_a ? sh_a : field(ca, LA, WA)); sv_a = 1'b0;
        q_b.push_back(sv_b ? sh_b : field(cb, LB, WB)); sv_b = 1'b0;
      end
      pa = rchat_n; pb = rchbt_n;
      old_a = ca; old_b = cb;
      if (en) n_en++;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      new_a = cnt_of(SA, PA, n_en);
      new_b = cnt_of(SB, PB, n_en);
      chk_eq("fs_a", 64'(fs_a), new_a);
      chk_eq("fs_n_a", 64'(fs_n_a), ~new_a & ((64'd1 << SA) - 64'd1));
      chk_eq("fpls_a", 64'(fpls_a), ~old_a & new_a);
      chk_eq("wrap_a", 64'(wrap_a), 64'(new_a == 0 && old_a != 0));
      chk_eq("rdv_a", 64'(rd_valid_a), 64'(q_a.size() != 0));
      if (q_a.size() != 0) last_a = q_a.pop_front();
      chk_eq("rdd_a", 64'(rd_data_a), last_a);
      chk_eq("fs_b", 64'(fs_b), new_b);
      chk_eq("fs_n_b", 64'(fs_n_b), ~new_b & ((64'd1 << SB) - 64'd1));
      chk_eq("fpls_b", 64'(fpls_b), ~old_b & new_b);
      chk_eq("wrap_b", 64'(wrap_b), 64'(new_b == 0 && old_b != 0));
      chk_eq("rdv_b", 64'(rd_valid_b), 64'(q_b.size() != 0));
      if (q_b.size() != 0) last_b = q_b.pop_front();
      chk_eq("rdd_b", 64'(rd_data_b), last_b);
`ifdef SCALER_STANDBY_EN
      chk_eq("sbypls_a", 64'(sbypls_a), ((~old_a & new_a) >> 2) & 64'd1);
      chk_eq("sbypls_b", 64'(sbypls_b), ((~old_b & new_b) >> 1) & 64'd1);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; rchat_n = 1'b1; rchbt_n = 1'b1;
    step(1);
    checking = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(40);
    for (int i = 0; i < 8; i++) begin
      rchat_n = 1'b0; step(1); rchat_n = 1'b1;
      step(1 + i * 3);
      rchbt_n = 1'b0; step(1); rchbt_n = 1'b1;
      step(2);
    end
    rchbt_n = 1'b0; step(2); rchbt_n = 1'b1; step(3);
    rchat_n = 1'b0; rchbt_n = 1'b0; step(5);
    rchat_n = 1'b1; rchbt_n = 1'b1; step(9);
    rchbt_n = 1'b0; step(1); rchbt_n = 1'b1; step(2);
    rchat_n = 1'b0; step(1); rchat_n = 1'b1; step(7);
    rchat_n = 1'b0; step(1); rchat_n = 1'b1; step(11);
    rchbt_n = 1'b0; step(1); rchbt_n = 1'b1; step(2);
    en = 1'b0; step(3);
    rchat_n = 1'b0; step(1); rchat_n = 1'b1; step(6);
    en = 1'b1; step(4);
    rchat_n = 1'b0; rst_n = 1'b0; step(1);
    rchat_n = 1'b1; step(2);
    rst_n = 1'b1; step(5);
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      rchat_n = ($urandom_range(0, 5) != 0);
      rchbt_n = ($urandom_range(0, 5) != 0);
      step(1);
    end
    rchat_n = 1'b1; rchbt_n = 1'b1; en = 1'b1;
    step(8300);
    rchat_n = 1'b0; step(1); rchat_n = 1'b1; step(3);
    rchbt_n = 1'b0; step(1); rchbt_n = 1'b1; step(3);
    checking = 1'b0;
    step(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
